// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mmu port between the core (c_*) and the SPI
// programming loader (p_*). One outstanding transaction, IDLE/ISSUE/WAIT
// sequencing, round-robin in normal mode, loader-only in programming mode,
// and a WAIT-state timeout that returns an error to the owning requester.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_programming_mode,

    input  logic        c_req_i,
    input  logic [31:0] c_addr_i,
    input  logic        c_we_i,
    input  logic [3:0]  c_be_i,
    input  logic [31:0] c_wdata_i,
    output logic        c_gnt_o,
    output logic        c_rvalid_o,
    output logic        c_err_o,
    output logic [31:0] c_rdata_o,

    input  logic        p_req_i,
    input  logic [31:0] p_addr_i,
    input  logic        p_we_i,
    input  logic [3:0]  p_be_i,
    input  logic [31:0] p_wdata_i,
    output logic        p_gnt_o,
    output logic        p_rvalid_o,
    output logic        p_err_o,
    output logic [31:0] p_rdata_o,

    output logic        m_req_o,
    output logic [31:0] m_addr_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_rvalid_i,
    input  logic        m_err_i,
    input  logic [31:0] m_rdata_i,

    output logic        busy_o,
    output logic        owner_o
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    // Owner encoding: 0 = core, 1 = loader
    localparam logic OWN_CORE   = 1'b0;
    localparam logic OWN_LOADER = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic          r_owner;
    logic          r_c_gnt;
    logic          r_p_gnt;
    logic          r_m_req;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [BW-1:0] r_be;
    logic [DW-1:0] r_wdata;

    logic          w_c_elig;
    logic          w_p_elig;
    logic          w_any;
    logic          w_win;
    logic          w_timeout;
    logic          w_resp;
    logic          w_err;
    logic [DW-1:0] w_rdata;
    logic          w_c_resp;
    logic          w_p_resp;

    // Arbitration: programming mode masks the core; a tie goes to whoever was not served last
    assign w_c_elig = c_req_i & ~set_programming_mode;
    assign w_p_elig = p_req_i;
    assign w_any    = w_c_elig | w_p_elig;
    assign w_win    = (w_c_elig & w_p_elig) ? ~r_last : w_p_elig;

    // Response path: a real mmu response beats a coincident timeout
    assign w_timeout = (r_state == S_WAIT) && !m_rvalid_i && (r_cnt == TO_LAST);
    assign w_resp    = (r_state == S_WAIT) && (m_rvalid_i || w_timeout);
    assign w_err     = m_rvalid_i ? m_err_i : 1'b1;
    assign w_rdata   = m_rvalid_i ? m_rdata_i : '0;
    assign w_c_resp  = w_resp && (r_owner == OWN_CORE);
    assign w_p_resp  = w_resp && (r_owner == OWN_LOADER);

    assign c_rvalid_o = w_c_resp;
    assign c_err_o    = w_c_resp & w_err;
    assign c_rdata_o  = w_c_resp ? w_rdata : '0;
    assign p_rvalid_o = w_p_resp;
    assign p_err_o    = w_p_resp & w_err;
    assign p_rdata_o  = w_p_resp ? w_rdata : '0;

    assign c_gnt_o   = r_c_gnt;
    assign p_gnt_o   = r_p_gnt;
    assign m_req_o   = r_m_req;
    assign m_addr_o  = r_addr;
    assign m_we_o    = r_we;
    assign m_be_o    = r_be;
    assign m_wdata_o = r_wdata;
    assign owner_o   = r_owner;
    assign busy_o    = (r_state != S_IDLE);

    // Transaction FSM: grant/capture in IDLE, one-cycle ISSUE, WAIT for response or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= OWN_LOADER;
            r_owner <= OWN_CORE;
            r_c_gnt <= 1'b0;
            r_p_gnt <= 1'b0;
            r_m_req <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
        end else begin
            r_c_gnt <= 1'b0;
            r_p_gnt <= 1'b0;
            r_m_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_c_gnt <= ~w_win;
                        r_p_gnt <= w_win;
                        r_m_req <= 1'b1;
                        r_addr  <= w_win ? p_addr_i  : c_addr_i;
                        r_we    <= w_win ? p_we_i    : c_we_i;
                        r_be    <= w_win ? p_be_i    : c_be_i;
                        r_wdata <= w_win ? p_wdata_i : c_wdata_i;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_resp) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the stimulus process pushes expected
// grants/responses, the monitor process pops and compares them as the DUT
// presents them, plus per-cycle protocol invariants.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        set_programming_mode;
    logic        c_req_i, c_we_i, p_req_i, p_we_i;
    logic [31:0] c_addr_i, c_wdata_i, p_addr_i, p_wdata_i;
    logic [3:0]  c_be_i, p_be_i;
    logic        c_gnt_o, c_rvalid_o, c_err_o, p_gnt_o, p_rvalid_o, p_err_o;
    logic [31:0] c_rdata_o, p_rdata_o;
    logic        m_req_o, m_we_o, m_rvalid_i, m_err_i;
    logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
    logic [3:0]  m_be_o;
    logic        busy_o, owner_o;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .set_programming_mode(set_programming_mode),
        .c_req_i(c_req_i), .c_addr_i(c_addr_i), .c_we_i(c_we_i), .c_be_i(c_be_i),
        .c_wdata_i(c_wdata_i), .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o),
        .c_err_o(c_err_o), .c_rdata_o(c_rdata_o),
        .p_req_i(p_req_i), .p_addr_i(p_addr_i), .p_we_i(p_we_i), .p_be_i(p_be_i),
        .p_wdata_i(p_wdata_i), .p_gnt_o(p_gnt_o), .p_rvalid_o(p_rvalid_o),
        .p_err_o(p_err_o), .p_rdata_o(p_rdata_o),
        .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
        .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i), .m_err_i(m_err_i),
        .m_rdata_i(m_rdata_i), .busy_o(busy_o), .owner_o(owner_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        who;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gap;
    } gnt_t;

    typedef struct {
        logic        who;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];

    // Written only by the monitor
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int rst_chk_done = 0;
    int idle_chk_done = 0;

    // Written only by the stimulus
    int   rst_chk_req = 0;
    int   idle_chk_req = 0;
    int   stim_to_fails = 0;
    logic stim_done = 1'b0;
    int   mmu_lat = 0;
    logic mmu_err = 1'b0;
    logic [31:0] mmu_rdata = '0;
    logic pend = 1'b0;
    int   pcnt = 0;
    logic c_one_shot = 1'b0;
    logic p_one_shot = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sample 2 time units after the falling edge, away from the active edge
    initial begin
        gnt_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (cyc > 4000) begin
                $display("FAIL watchdog: got cycle %0d, want below 4000", cyc);
                $fatal(1, "watchdog expired");
            end
            chk("invariants", 64'({
                !(c_gnt_o && p_gnt_o),
                (m_req_o == (c_gnt_o || p_gnt_o)),
                !(c_rvalid_o && p_rvalid_o),
                (c_rvalid_o || c_rdata_o == 32'h0),
                (p_rvalid_o || p_rdata_o == 32'h0)}), 64'h1F);
            if (rst_chk_req != rst_chk_done) begin
                rst_chk_done = rst_chk_req;
                chk("rst_ctrl", 64'({c_gnt_o, p_gnt_o, c_rvalid_o, p_rvalid_o, c_err_o, p_err_o,
                                     m_req_o, m_we_o, busy_o, owner_o, m_be_o}), 64'h0);
                chk("rst_rdata", {c_rdata_o, p_rdata_o}, 64'h0);
                chk("rst_mfields", {m_addr_o, m_wdata_o}, 64'h0);
            end
            if (idle_chk_req != idle_chk_done) begin
                idle_chk_done = idle_chk_req;
                chk("idle_ctrl", 64'({c_gnt_o, p_gnt_o, c_rvalid_o, p_rvalid_o, c_err_o, p_err_o,
                                      m_req_o, busy_o}), 64'h0);
                chk("idle_rdata", {c_rdata_o, p_rdata_o}, 64'h0);
            end
            if (c_gnt_o || p_gnt_o) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 64'(p_gnt_o), 64'h2);
                end else begin
                    g = gq.pop_front();
                    chk("grant_who", 64'(p_gnt_o), 64'(g.who));
                    chk("grant_owner_busy", 64'({owner_o, busy_o}), 64'({g.who, 1'b1}));
                    chk("grant_addr", 64'(m_addr_o), 64'(g.addr));
                    chk("grant_we_be_wdata", 64'({m_we_o, m_be_o, m_wdata_o}),
                        64'({g.we, g.be, g.wdata}));
                    if (g.gap != 0) chk("grant_gap", 64'(cyc - last_gnt_cyc), 64'(g.gap));
                end
                last_gnt_cyc = cyc;
            end
            if (c_rvalid_o || p_rvalid_o) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", 64'({p_rvalid_o, c_rvalid_o}), 64'h0);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_who", 64'({p_rvalid_o, owner_o}), 64'({r.who, r.who}));
                    chk("rsp_err", 64'(p_rvalid_o ? p_err_o : c_err_o), 64'(r.err));
                    chk("rsp_rdata", 64'(p_rvalid_o ? p_rdata_o : c_rdata_o), 64'(r.rdata));
                    chk("rsp_latency", 64'(cyc - last_gnt_cyc), 64'(r.lat));
                end
            end
            if (stim_done) begin
                chk("grants_left", 64'(gq.size()), 64'h0);
                chk("rsps_left", 64'(rq.size()), 64'h0);
                chk("bounded_waits", 64'(stim_to_fails), 64'h0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    // One cycle of stimulus; models the mmu answering mmu_lat cycles after m_req_o
    task automatic tick();
        @(negedge clk);
        m_rvalid_i = 1'b0;
        m_err_i    = 1'b0;
        m_rdata_i  = '0;
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                m_rvalid_i = 1'b1;
                m_err_i    = mmu_err;
                m_rdata_i  = mmu_rdata;
                pend       = 1'b0;
            end
        end
        if (m_req_o && mmu_lat != 0) begin
            pend = 1'b1;
            pcnt = mmu_lat;
        end
        if (c_one_shot && c_gnt_o) begin
            c_req_i    = 1'b0;
            c_one_shot = 1'b0;
        end
        if (p_one_shot && p_gnt_o) begin
            p_req_i    = 1'b0;
            p_one_shot = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_gnt(input int maxc, output logic who);
        who = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (c_gnt_o || p_gnt_o) begin
                who = p_gnt_o;
                return;
            end
        end
        stim_to_fails++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        c_req_i = 1'b0;
        p_req_i = 1'b0;
        set_programming_mode = 1'b0;
        ticks(2);
        rst = 1'b0;
        pend = 1'b0;
        rst_chk_req++;
    endtask

    task automatic push_g(input logic who, input logic [31:0] a, input logic we,
                          input logic [3:0] be, input logic [31:0] wd, input int gap);
        gnt_t g;
        g.who = who; g.addr = a; g.we = we; g.be = be; g.wdata = wd; g.gap = gap;
        gq.push_back(g);
    endtask

    task automatic push_r(input logic who, input logic err, input logic [31:0] rd, input int lat);
        rsp_t r;
        r.who = who; r.err = err; r.rdata = rd; r.lat = lat;
        rq.push_back(r);
    endtask

    initial begin
        logic w;
        int   np;
        rst = 1'b1;
        set_programming_mode = 1'b0;
        c_req_i = 1'b0; c_addr_i = '0; c_we_i = 1'b0; c_be_i = '0; c_wdata_i = '0;
        p_req_i = 1'b0; p_addr_i = '0; p_we_i = 1'b0; p_be_i = '0; p_wdata_i = '0;
        m_rvalid_i = 1'b0; m_err_i = 1'b0; m_rdata_i = '0;

        // Single core write, mmu answers 2 cycles after m_req_o
        do_reset();
        mmu_lat = 2; mmu_err = 1'b0; mmu_rdata = 32'hA5A5_0001;
        c_addr_i = 32'h0000_0102; c_we_i = 1'b1; c_be_i = 4'hF; c_wdata_i = 32'h1;
        push_g(1'b0, 32'h0000_0102, 1'b1, 4'hF, 32'h1, 0);
        push_r(1'b0, 1'b0, 32'hA5A5_0001, 2);
        c_one_shot = 1'b1;
        c_req_i = 1'b1;
        wait_gnt(10, w);
        ticks(4);
        idle_chk_req++;

        // Normal mode, both held: core, loader, core, loader, one grant every 3 cycles
        do_reset();
        mmu_lat = 1; mmu_rdata = 32'h1111_2222;
        c_addr_i = 32'h0000_1000; c_we_i = 1'b0; c_be_i = 4'hF; c_wdata_i = 32'h0;
        p_addr_i = 32'h0000_2000; p_we_i = 1'b1; p_be_i = 4'h3; p_wdata_i = 32'hCAFE_F00D;
        push_g(1'b0, 32'h0000_1000, 1'b0, 4'hF, 32'h0, 0);
        push_g(1'b1, 32'h0000_2000, 1'b1, 4'h3, 32'hCAFE_F00D, 3);
        push_g(1'b0, 32'h0000_1000, 1'b0, 4'hF, 32'h0, 3);
        push_g(1'b1, 32'h0000_2000, 1'b1, 4'h3, 32'hCAFE_F00D, 3);
        for (int k = 0; k < 4; k++) push_r(k[0], 1'b0, 32'h1111_2222, 1);
        c_req_i = 1'b1;
        p_req_i = 1'b1;
        for (int k = 0; k < 4; k++) wait_gnt(10, w);
        c_req_i = 1'b0;
        p_req_i = 1'b0;
        ticks(4);

        // Programming mode: loader only; core wins the first arbitration after the mode drops
        do_reset();
        set_programming_mode = 1'b1;
        mmu_lat = 1; mmu_rdata = 32'h3333_4444;
        push_g(1'b1, 32'h0000_2000, 1'b1, 4'h3, 32'hCAFE_F00D, 0);
        for (int k = 0; k < 3; k++) push_g(1'b1, 32'h0000_2000, 1'b1, 4'h3, 32'hCAFE_F00D, 3);
        push_g(1'b0, 32'h0000_1000, 1'b0, 4'hF, 32'h0, 3);
        for (int k = 0; k < 4; k++) push_r(1'b1, 1'b0, 32'h3333_4444, 1);
        push_r(1'b0, 1'b0, 32'h3333_4444, 1);
        c_req_i = 1'b1;
        p_req_i = 1'b1;
        np = 0;
        for (int k = 0; k < 8 && np < 4; k++) begin
            wait_gnt(10, w);
            if (w) np++;
        end
        set_programming_mode = 1'b0;
        wait_gnt(10, w);
        c_req_i = 1'b0;
        p_req_i = 1'b0;
        ticks(4);

        // Loader read with no mmu answer: error on the 8th WAIT cycle; late answer dropped
        do_reset();
        mmu_lat = 0;
        p_addr_i = 32'h0000_3000; p_we_i = 1'b0; p_be_i = 4'hF; p_wdata_i = 32'h0;
        push_g(1'b1, 32'h0000_3000, 1'b0, 4'hF, 32'h0, 0);
        push_r(1'b1, 1'b1, 32'h0, 8);
        p_one_shot = 1'b1;
        p_req_i = 1'b1;
        wait_gnt(10, w);
        ticks(8);
        ticks(3);
        m_rvalid_i = 1'b1; m_err_i = 1'b0; m_rdata_i = 32'h5555_AAAA;
        idle_chk_req++;
        ticks(2);

        // Response coinciding with the timeout cycle is a normal response
        do_reset();
        mmu_lat = 8; mmu_err = 1'b0; mmu_rdata = 32'hDEAD_BEEF;
        c_addr_i = 32'h0000_4000; c_we_i = 1'b0; c_be_i = 4'hF; c_wdata_i = 32'h0;
        push_g(1'b0, 32'h0000_4000, 1'b0, 4'hF, 32'h0, 0);
        push_r(1'b0, 1'b0, 32'hDEAD_BEEF, 8);
        c_one_shot = 1'b1;
        c_req_i = 1'b1;
        wait_gnt(10, w);
        ticks(10);

        // Reset during WAIT aborts the transaction; following response is dropped
        do_reset();
        mmu_lat = 0;
        c_addr_i = 32'h0000_5000; c_we_i = 1'b1; c_be_i = 4'h1; c_wdata_i = 32'h77;
        push_g(1'b0, 32'h0000_5000, 1'b1, 4'h1, 32'h77, 0);
        c_one_shot = 1'b1;
        c_req_i = 1'b1;
        wait_gnt(10, w);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_rvalid_i = 1'b1; m_err_i = 1'b1; m_rdata_i = 32'hBAD0_0BAD;
        rst_chk_req++;
        tick();
        mmu_lat = 1; mmu_rdata = 32'h0BAD_F00D;
        c_addr_i = 32'h0000_6000; c_we_i = 1'b0; c_be_i = 4'hF; c_wdata_i = 32'h0;
        push_g(1'b0, 32'h0000_6000, 1'b0, 4'hF, 32'h0, 0);
        push_r(1'b0, 1'b0, 32'h0BAD_F00D, 1);
        c_one_shot = 1'b1;
        c_req_i = 1'b1;
        wait_gnt(10, w);
        ticks(4);

        stim_done = 1'b1;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max WAIT cycles before a transaction is aborted with error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 set_programming_mode  input  1  1 = programming loader has exclusive access; core is blocked.
REQ-005 Requester ports use prefix x ∈ {c = Vicuna/Ibex core, p = programming SPI loader}; each listed line defines both.
REQ-006 x_req_i  input  1  request; held with its fields until x_gnt_o.
REQ-007 x_addr_i  input  32  byte address.
REQ-008 x_we_i  input  1  1 = write, 0 = read.
REQ-009 x_be_i  input  4  byte enables.
REQ-010 x_wdata_i  input  32  write data.
REQ-011 x_gnt_o  output  1  one-cycle pulse: request accepted, fields captured.
REQ-012 x_rvalid_o  output  1  one-cycle response pulse to the owning requester.
REQ-013 x_err_o  output  1  error qualifier, valid with x_rvalid_o.
REQ-014 x_rdata_o  output  32  read data, valid with x_rvalid_o.
REQ-015 m_req_o  output  1  one-cycle request pulse to mmu.
REQ-016 m_addr_o / m_we_o / m_be_o / m_wdata_o  output  32/1/4/32  captured fields of the granted request; held stable from ISSUE until return to IDLE.
REQ-017 m_rvalid_i  input  1  mmu response strobe.
REQ-018 m_err_i  input  1  mmu error, valid with m_rvalid_i.
REQ-019 m_rdata_i  input  32  mmu read data.
REQ-020 busy_o  output  1  high in ISSUE and WAIT.
REQ-021 owner_o  output  1  0 = core, 1 = loader; meaningful only while busy_o = 1.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT; one outstanding transaction max.
REQ-023 IDLE: if an eligible request is present at edge N, capture the winner's fields, set owner_o, go ISSUE; m_req_o and x_gnt_o are high during cycle N+1 only.
REQ-024 ISSUE -> WAIT unconditionally; m_rvalid_i during ISSUE is ignored (earliest legal response is the first WAIT cycle).
REQ-025 WAIT: x_rvalid_o = m_rvalid_i, x_err_o = m_err_i, x_rdata_o = m_rdata_i, combinational, owner only; the same edge returns to IDLE.
REQ-026 Non-owner x_rvalid_o / x_err_o always 0; all x_rdata_o = 0 when their x_rvalid_o = 0.
REQ-027 Normal mode arbitration is round-robin: a single requester wins; on a tie the requester not last served wins.
REQ-028 Programming mode: only the loader is eligible; c_req_i is never granted while set_programming_mode = 1.
REQ-029 Mode change mid-transaction does not abort the transaction; the new mode applies at the next IDLE arbitration.
REQ-030 Timeout counter: 8 bits wide, cleared on entering WAIT, incremented each WAIT cycle without m_rvalid_i.
REQ-031 Timeout: on the WAIT cycle where the count equals TIMEOUT-1 with no m_rvalid_i, pulse owner x_rvalid_o = 1, x_err_o = 1, x_rdata_o = 0, then go IDLE.
REQ-032 Simultaneous m_rvalid_i and timeout: treat as a normal response (REQ-025), with no forced error.
REQ-033 m_rvalid_i in IDLE (a late response after timeout) is dropped and forwarded to no one.
REQ-034 A new arbitration may occur in the IDLE cycle immediately after the response cycle; back-to-back throughput is one transaction per 3 cycles with a 1-cycle mmu response.

Reset
REQ-035 rst = 1 at an edge forces IDLE, clears the timeout counter and sets last-served = loader (the core wins the first tie); this applies from any state, including mid-WAIT.
REQ-036 Reset values: all m_* outputs, x_gnt_o, x_rvalid_o, x_err_o, x_rdata_o, busy_o and owner_o are 0; a pending mmu response arriving after reset is dropped per REQ-033.

Verification
REQ-037 Core write addr 0x0000_0102, wdata 0x1, be 0xF, mmu rvalid 2 cycles after m_req_o -> m_req_o and c_gnt_o high for 1 cycle with those fields; c_rvalid_o = 1, c_err_o = 0; all p_* outputs 0.
REQ-038 Normal mode, both requesters held high, 1-cycle mmu response -> grant order core, loader, core, loader; 4 transactions in 12 cycles.
REQ-039 Programming mode, both held high for 4 transactions -> p_gnt_o 4 times, c_gnt_o never asserted; after mode drops the next grant goes to the core.
REQ-040 TIMEOUT = 8, loader read with no mmu response -> on the 8th WAIT cycle p_rvalid_o = 1, p_err_o = 1, p_rdata_o = 0; a m_rvalid_i 3 cycles later is not forwarded.
REQ-041 TIMEOUT = 8, m_rvalid_i with rdata 0xDEAD_BEEF on the 8th WAIT cycle -> c_rvalid_o = 1, c_err_o = 0, c_rdata_o = 0xDEAD_BEEF.
REQ-042 rst pulsed during WAIT, then m_rvalid_i -> the next cycle is IDLE with all outputs 0; the response is not forwarded; the next core request is granted normally.
